// File: rtl/eth_arb_pkg.sv
// eth_arb_pkg: shared types and defaults for the 10G TX stream arbiter.
// Used by the arbiter top and its round-robin picker.
package eth_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_PASS} arb_state_t;

  localparam int N_SRC_DEF       = 2;
  localparam int DATA_W_DEF      = 32;
  localparam int STALL_LIMIT_DEF = 3;
  localparam int CNT_W_DEF       = 16;

  function automatic int gidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_axis_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first requester strictly after the pointer, wrapping.
module rr_pick
  import eth_arb_pkg::*;
#(
  parameter int N     = N_SRC_DEF,
  parameter int IDX_W = gidx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/eth_tx_axis_arbiter.sv
// eth_tx_axis_arbiter: packet-granular round-robin arbiter in front of the
// 10G MAC TX AXI-Stream slave, with packet counter and mid-packet stall flag.
module eth_tx_axis_arbiter
  import eth_arb_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                          i_tx_clk,
  input  logic                          i_tx_reset,
  input  logic [N_SRC-1:0]              s_axis_tvalid,
  input  logic [N_SRC*DATA_W-1:0]       s_axis_tdata,
  input  logic [N_SRC*(DATA_W/8)-1:0]   s_axis_tkeep,
  input  logic [N_SRC-1:0]              s_axis_tlast,
  output logic [N_SRC-1:0]              s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic [(DATA_W/8)-1:0]         m_axis_tkeep,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [gidx_w(N_SRC)-1:0]      o_grant_idx,
  output logic                          o_busy,
  output logic [CNT_W-1:0]              o_pkt_count,
  output logic                          o_stall_err
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int GIDX_W = gidx_w(N_SRC);
  localparam int SW     = $clog2(STALL_LIMIT + 2);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT + 1);

  arb_state_t        state_q;
  logic [GIDX_W-1:0] grant_q;
  logic [GIDX_W-1:0] rr_q;
  logic [GIDX_W-1:0] pick_idx;
  logic              pick_valid;
  logic              started_q;
  logic              stall_err_q;
  logic [SW-1:0]     stall_q;
  logic [SW-1:0]     stall_d;
  logic [CNT_W-1:0]  pkt_cnt_q;
  logic              busy;
  logic              g_valid;
  logic              hs;
  logic              hs_last;

  rr_pick #(
    .N     (N_SRC),
    .IDX_W (GIDX_W)
  ) u_pick (
    .req_i   (s_axis_tvalid),
    .ptr_i   (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign busy          = (state_q == ARB_PASS);
  assign g_valid       = s_axis_tvalid[grant_q];
  assign m_axis_tvalid = busy & g_valid;
  assign m_axis_tdata  = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
  assign m_axis_tkeep  = s_axis_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
  assign m_axis_tlast  = s_axis_tlast[grant_q];
  assign hs            = m_axis_tvalid & m_axis_tready;
  assign hs_last       = hs & m_axis_tlast;

  always_comb begin
    s_axis_tready = '0;
    if (busy) s_axis_tready[grant_q] = m_axis_tready;
  end

  // Only gaps after the first beat count; saturates one past the limit.
  always_comb begin
    stall_d = '0;
    if (busy && !g_valid) begin
      stall_d = stall_q;
      if (started_q && stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge i_tx_clk) begin
    if (i_tx_reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_q        <= GIDX_W'(N_SRC - 1);
      started_q   <= 1'b0;
      stall_q     <= '0;
      stall_err_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      stall_q <= stall_d;
      if (stall_d == STALL_MAX) stall_err_q <= 1'b1;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_q   <= pick_idx;
            started_q <= 1'b0;
            state_q   <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (hs) started_q <= 1'b1;
          if (hs_last) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
            rr_q      <= grant_q;
            state_q   <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign o_grant_idx = grant_q;
  assign o_busy      = busy;
  assign o_pkt_count = pkt_cnt_q;
  assign o_stall_err = stall_err_q;

endmodule

// File: tb/tb_eth_tx_axis_arbiter.sv
// tb_eth_tx_axis_arbiter: directed and randomized checks of the TX arbiter
// against a packet-level round-robin scoreboard.
module tb_eth_tx_axis_arbiter;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int KW = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    bit            last;
    int            gap;
  } beat_t;

  typedef struct {
    int    src;
    beat_t b;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [NS-1:0]    s_tvalid;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tready;
  logic             m_tvalid;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast;
  logic             m_tready;
  logic [1:0]       grant_idx;
  logic             busy;
  logic [15:0]      pkt_count;
  logic             stall_err;

  beat_t srcq[NS][$];
  exp_t  expq[$];
  int    got_order[$];
  int    gcnt[NS];
  int    model_rr;
  int    exp_pkts;
  int    first_hs;
  int    n_checks;
  int    n_pass;

  eth_tx_axis_arbiter #(
    .N_SRC       (NS),
    .DATA_W      (DW),
    .STALL_LIMIT (3),
    .CNT_W       (16)
  ) dut (
    .i_tx_clk      (clk),
    .i_tx_reset    (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .o_grant_idx   (grant_idx),
    .o_busy        (busy),
    .o_pkt_count   (pkt_count),
    .o_stall_err   (stall_err)
  );

  always #5 clk = ~clk;

  function automatic void add_pkt(input int s, input int nb,
                                  input int gap_beat, input int gap_len,
                                  input bit rnd_gaps);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.d    = $urandom;
      b.last = (i == nb - 1);
      b.k    = b.last ? KW'($urandom_range(1, 15)) : '1;
      b.gap  = (i == gap_beat) ? gap_len : 0;
      if (rnd_gaps && i > 0 && $urandom_range(0, 2) == 0)
        b.gap = $urandom_range(1, 2);
      srcq[s].push_back(b);
    end
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    model_rr = NS - 1;
    exp_pkts = 0;
    for (int i = 0; i < NS; i++) gcnt[i] = 0;
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i]          = 1'b0;
      s_tlast[i]           = 1'b0;
      s_tdata[i*DW +: DW]  = $urandom;
      s_tkeep[i*KW +: KW]  = '0;
      if (srcq[i].size() > 0) begin
        if (gcnt[i] > 0) begin
          gcnt[i]--;
        end else begin
          s_tvalid[i]         = 1'b1;
          s_tdata[i*DW +: DW] = srcq[i][0].d;
          s_tkeep[i*KW +: KW] = srcq[i][0].k;
          s_tlast[i]          = srcq[i][0].last;
        end
      end
    end
  endtask

  // Packet-level model: whole packets, next non-empty source after the last winner.
  task automatic build_expect();
    beat_t cp[NS][$];
    exp_t  e;
    int    s;
    for (int i = 0; i < NS; i++) cp[i] = srcq[i];
    expq.delete();
    forever begin
      s = -1;
      for (int k = 1; k <= NS; k++) begin
        if (s < 0 && cp[(model_rr + k) % NS].size() > 0) s = (model_rr + k) % NS;
      end
      if (s < 0) break;
      do begin
        e.src = s;
        e.b   = cp[s].pop_front();
        expq.push_back(e);
      end while (!e.b.last);
      model_rr = s;
    end
  endtask

  task automatic run_traffic(input int rdy_pct, input int hold_at,
                             input bit exp_err, input int max_cyc);
    int            cyc;
    int            es;
    bit            prev_hold;
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    logic          pl;
    exp_t          e;
    build_expect();
    got_order.delete();
    first_hs  = -1;
    cyc       = 0;
    prev_hold = 1'b0;
    while (expq.size() > 0 && cyc < max_cyc) begin
      drive_srcs();
      if (cyc >= hold_at && cyc < hold_at + 5) m_tready = 1'b0;
      else m_tready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      es = expq[0].src;
      for (int i = 0; i < NS; i++) begin
        if (i != es) begin
          n_checks++;
          if (s_tready[i] !== 1'b0)
            $display("FAIL loser_tready src%0d: got %b want 0 (cyc %0d)", i, s_tready[i], cyc);
          else n_pass++;
        end
      end
      if (m_tvalid === 1'b1) begin
        n_checks++;
        if (s_tready[es] !== m_tready)
          $display("FAIL winner_tready: got %b want %b", s_tready[es], m_tready);
        else n_pass++;
      end
      if (prev_hold) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl)
          $display("FAIL hold_stable: got v%b %h/%h/%b want v1 %h/%h/%b",
                   m_tvalid, m_tdata, m_tkeep, m_tlast, pd, pk, pl);
        else n_pass++;
      end
      prev_hold = (m_tvalid === 1'b1) && !m_tready;
      pd = m_tdata;
      pk = m_tkeep;
      pl = m_tlast;
      if (m_tvalid === 1'b1 && m_tready) begin
        e = expq.pop_front();
        if (first_hs < 0) first_hs = cyc;
        n_checks++;
        if (m_tdata !== e.b.d || m_tkeep !== e.b.k || m_tlast !== e.b.last)
          $display("FAIL beat: got %h/%h/%b want %h/%h/%b",
                   m_tdata, m_tkeep, m_tlast, e.b.d, e.b.k, e.b.last);
        else n_pass++;
        n_checks++;
        if (int'(grant_idx) != e.src)
          $display("FAIL grant_idx: got %0d want %0d", grant_idx, e.src);
        else n_pass++;
        if (e.b.last) begin
          got_order.push_back(int'(grant_idx));
          exp_pkts++;
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (s_tvalid[i] && s_tready[i] === 1'b1 && srcq[i].size() > 0) begin
          void'(srcq[i].pop_front());
          gcnt[i] = (srcq[i].size() > 0) ? srcq[i][0].gap : 0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (expq.size() != 0) begin
      $display("FAIL timeout: %0d beats left after %0d cycles, want 0", expq.size(), cyc);
      for (int i = 0; i < NS; i++) srcq[i].delete();
    end else n_pass++;
    drive_srcs();
    m_tready = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL end_idle: busy got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (pkt_count !== 16'(exp_pkts))
      $display("FAIL pkt_count: got %0d want %0d", pkt_count, exp_pkts);
    else n_pass++;
    n_checks++;
    if (stall_err !== exp_err)
      $display("FAIL stall_err: got %b want %b", stall_err, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || s_tready !== '0 || grant_idx !== 2'd0 ||
        busy !== 1'b0 || pkt_count !== 16'd0 || stall_err !== 1'b0)
      $display("FAIL reset: got v%b r%b g%0d b%b c%0d e%b want all 0",
               m_tvalid, s_tready, grant_idx, busy, pkt_count, stall_err);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    add_pkt(0, 3, -1, 0, 1'b0);
    run_traffic(100, -100, 1'b0, 50);
    n_checks++;
    if (first_hs != 1) $display("FAIL grant_latency: got %0d want 1", first_hs);
    else n_pass++;
  endtask

  task automatic test_alternate();
    int want[4] = '{0, 1, 0, 1};
    do_reset();
    for (int p = 0; p < 2; p++) begin
      add_pkt(0, 2, -1, 0, 1'b0);
      add_pkt(1, 2, -1, 0, 1'b0);
    end
    run_traffic(100, -100, 1'b0, 100);
    n_checks++;
    if (got_order.size() != 4) $display("FAIL order_len: got %0d want 4", got_order.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < got_order.size(); i++) begin
      n_checks++;
      if (got_order[i] != want[i])
        $display("FAIL order[%0d]: got %0d want %0d", i, got_order[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    add_pkt(2, 4, -1, 0, 1'b0);
    run_traffic(100, 2, 1'b0, 100);
  endtask

  task automatic test_stall();
    add_pkt(0, 4, 1, 3, 1'b0);
    run_traffic(100, -100, 1'b0, 100);
    add_pkt(0, 4, 1, 4, 1'b0);
    run_traffic(100, -100, 1'b1, 100);
    add_pkt(1, 3, -1, 0, 1'b0);
    run_traffic(100, -100, 1'b1, 100);
  endtask

  task automatic test_reset_mid();
    s_tvalid          = 3'b001;
    s_tdata[0 +: DW]  = 32'hA0A0_0001;
    s_tkeep[0 +: KW]  = '1;
    s_tlast           = '0;
    m_tready          = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_tdata[0 +: DW]  = 32'hA0A0_0002;
    n_checks++;
    if (m_tvalid !== 1'b1) $display("FAIL mid_beat2: tvalid got %b want 1", m_tvalid);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0 || pkt_count !== 16'd0 ||
        stall_err !== 1'b0 || grant_idx !== 2'd0)
      $display("FAIL mid_reset: got b%b v%b c%0d e%b g%0d want 0 0 0 0 0",
               busy, m_tvalid, pkt_count, stall_err, grant_idx);
    else n_pass++;
    do_reset();
    add_pkt(1, 3, -1, 0, 1'b0);
    run_traffic(100, -100, 1'b0, 50);
    n_checks++;
    if (got_order.size() != 1 || got_order[0] != 1)
      $display("FAIL post_reset_grant: got %p want '{1}", got_order);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int s = 0; s < NS; s++) begin
      int np = $urandom_range(2, 4);
      for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 5), -1, 0, 1'b1);
    end
    run_traffic(70, -100, 1'b0, 2000);
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    n_checks = 0;
    n_pass   = 0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_stall();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
